// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - SPI master with configurable word width, chip selects, SPI mode and optional CRC7
//
// Purpose:
//   Shifts one DATA_W-bit word out on MOSI (MSB first) and captures one word from MISO.
//   The SCLK half-period is DIV+1 system clocks. The block steps through IDLE -> SETUP -> SHIFT -> DONE.
//   Optional feature macro: SPI_MASTER_CRC7_EN. When it is defined, CRC7 tracks a running
//   CRC-7 (x^7+x^3+1) of the MOSI bits. When it is undefined, CRC7 is tied to zero.
//
// Ports:
//   CLOCK50   - system clock; all logic runs on its rising edge
//   RESET     - asynchronous active-low reset
//   TX_STB    - transfer request, held by the requester until TX_ACK
//   TX_DATA   - word to transmit
//   TX_ACK    - one-cycle pulse in the cycle whose closing edge accepts the request
//   CS_SEL    - chip-select mask (one-hot or multi-hot), sampled on accept
//   CS_HOLD   - keep CS asserted after the transfer, sampled on accept
//   CFG_STB   - load CFG_DIV / CFG_CPOL / CFG_CPHA (IDLE only)
//   CFG_DIV   - divider value; SCLK half-period is CFG_DIV+1 cycles
//   CFG_CPOL  - SCLK idle level
//   CFG_CPHA  - clock phase
//   RES_STB   - one-cycle pulse when RES_DATA is updated
//   RES_DATA  - received word, held until the next RES_STB
//   BUSY      - high from accept until the end of DONE
//   MOSI      - serial data out
//   MISO      - serial data in
//   SCLK      - serial clock
//   CS        - active-low chip selects
//   CRC_CLR   - clears the CRC accumulator
//   CRC7      - running CRC7 of the MOSI bits
module spi_master_gen #(
  parameter int DATA_W    = 8,
  parameter int CS_CNT    = 1,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 62
) (
  input  logic              CLOCK50,
  input  logic              RESET,
  input  logic              TX_STB,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_ACK,
  input  logic [CS_CNT-1:0] CS_SEL,
  input  logic              CS_HOLD,
  input  logic              CFG_STB,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              CFG_CPOL,
  input  logic              CFG_CPHA,
  output logic              RES_STB,
  output logic [DATA_W-1:0] RES_DATA,
  output logic              BUSY,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SCLK,
  output logic [CS_CNT-1:0] CS,
  input  logic              CRC_CLR,
  output logic [6:0]        CRC7
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIV_W-1:0]  r_div;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_hold;
  logic [DIV_W-1:0]  r_cnt;
  logic [EW-1:0]     r_edge;
  logic              r_sclk;
  // One spare bit so that both phases drive MOSI from the top bit:
  // CPHA=0 loads {data,1} (MSB visible at once), CPHA=1 loads {1,data}
  // so that the first leading edge shifts the MSB onto the line.
  logic [DATA_W:0]   r_sh;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_stb;
  logic [CS_CNT-1:0] r_cs;

  logic              w_tx_ack;
  logic              w_busy;
  logic              w_tick;
  logic              w_running;
  logic              w_edge_go;
  logic [EW-1:0]     w_edge_num;
  logic              w_sample;
  logic              w_shift_en;
  logic              w_sample_en;

  // SETUP's closing tick produces SCLK edge 1; each SHIFT half-period tick
  // produces the next edge until edge 2*DATA_W has been made. The final
  // half-period of SHIFT therefore sits at the CPOL level.
  assign w_tick      = (r_cnt == r_div);
  assign w_running   = (r_state == S_SETUP) ||
                       ((r_state == S_SHIFT) && (r_edge != LAST_EDGE));
  assign w_edge_go   = w_running && w_tick;
  assign w_edge_num  = r_edge + 1'b1;
  // CPHA=0 samples on odd edges; CPHA=1 samples on even edges.
  assign w_sample    = w_edge_num[0] ^ r_cpha;
  assign w_shift_en  = w_edge_go && !w_sample;
  assign w_sample_en = w_edge_go && w_sample;

  // State register
  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a configuration load in IDLE takes precedence over a request
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (TX_STB && !CFG_STB) w_next = S_SETUP;
      S_SETUP: if (w_tick) w_next = S_SHIFT;
      S_SHIFT: if (w_tick && (r_edge == LAST_EDGE)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode. TX_ACK is gated by RESET so that a request held during reset is not acknowledged.
  always_comb begin
    w_tx_ack = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_ack = RESET & TX_STB & ~CFG_STB;
        w_busy   = 1'b0;
      end
      default: begin
        w_tx_ack = 1'b0;
        w_busy   = 1'b1;
      end
    endcase
  end

  // Datapath: configuration, divider, shifter, chip selects, result
  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      r_div      <= DIV_W'(DIV_RESET);
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_hold     <= 1'b0;
      r_cnt      <= '0;
      r_edge     <= '0;
      r_sclk     <= 1'b0;
      r_sh       <= '1;
      r_rx       <= '0;
      r_res_data <= '0;
      r_res_stb  <= 1'b0;
      r_cs       <= '1;
    end else begin
      r_res_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_edge <= '0;
          if (CFG_STB) begin
            r_div  <= CFG_DIV;
            r_cpol <= CFG_CPOL;
            r_cpha <= CFG_CPHA;
            r_sclk <= CFG_CPOL;
          end else if (TX_STB) begin
            r_sh   <= r_cpha ? {1'b1, TX_DATA} : {TX_DATA, 1'b1};
            r_cs   <= ~CS_SEL;
            r_hold <= CS_HOLD;
          end
        end
        S_SETUP, S_SHIFT: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_edge_go) begin
            r_edge <= w_edge_num;
            r_sclk <= ~r_sclk;
          end
          if (w_shift_en) begin
            r_sh <= {r_sh[DATA_W-1:0], 1'b1};
          end
          if (w_sample_en) begin
            r_rx <= {r_rx[DATA_W-2:0], MISO};
          end
        end
        S_DONE: begin
          r_res_stb  <= 1'b1;
          r_res_data <= r_rx;
          r_sh       <= '1;
          if (!r_hold) begin
            r_cs <= '1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_CRC7_EN
  logic [6:0] r_crc;
  logic       w_crc_bit;
  logic       w_crc_fb;

  // The CRC bit is the data bit that this shift concerns. For CPHA=0 it is the bit leaving MOSI.
  // For CPHA=1 it is the bit arriving on MOSI.
  assign w_crc_bit = r_cpha ? r_sh[DATA_W-1] : r_sh[DATA_W];
  assign w_crc_fb  = r_crc[6] ^ w_crc_bit;

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      r_crc <= 7'd0;
    end else if (CRC_CLR) begin
      r_crc <= 7'd0;
    end else if (w_shift_en) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);
    end
  end

  assign CRC7 = r_crc;
`else
  logic w_unused_crc_clr;
  assign w_unused_crc_clr = CRC_CLR;
  assign CRC7 = 7'd0;
`endif

  assign TX_ACK   = w_tx_ack;
  assign BUSY     = w_busy;
  assign RES_STB  = r_res_stb;
  assign RES_DATA = r_res_data;
  assign MOSI     = r_sh[DATA_W];
  assign SCLK     = r_sclk;
  assign CS       = r_cs;

endmodule

// File: tb/tb_spi_master_gen.sv
// tb/tb_spi_master_gen.sv - directed self-checking bench for spi_master_gen
module tb_spi_master_gen;

  logic       clk;
  logic       rst_n;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic [1:0] cs_sel;
  logic       cs_hold;
  logic       cfg_stb;
  logic [7:0] cfg_div;
  logic       cfg_cpol;
  logic       cfg_cpha;
  logic       res_stb;
  logic [7:0] res_data;
  logic       busy;
  logic       mosi;
  logic       miso;
  logic       sclk;
  logic [1:0] cs;
  logic       crc_clr;
  logic [6:0] crc7;

  logic       loop_en;
  logic       miso_drv;
  logic       cur_cpol;

  int errors;
  int checks;

  assign miso = loop_en ? mosi : miso_drv;

  spi_master_gen #(
    .DATA_W(8),
    .CS_CNT(2),
    .DIV_W(8),
    .DIV_RESET(62)
  ) dut (
    .CLOCK50 (clk),
    .RESET   (rst_n),
    .TX_STB  (tx_stb),
    .TX_DATA (tx_data),
    .TX_ACK  (tx_ack),
    .CS_SEL  (cs_sel),
    .CS_HOLD (cs_hold),
    .CFG_STB (cfg_stb),
    .CFG_DIV (cfg_div),
    .CFG_CPOL(cfg_cpol),
    .CFG_CPHA(cfg_cpha),
    .RES_STB (res_stb),
    .RES_DATA(res_data),
    .BUSY    (busy),
    .MOSI    (mosi),
    .MISO    (miso),
    .SCLK    (sclk),
    .CS      (cs),
    .CRC_CLR (crc_clr),
    .CRC7    (crc7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg(input logic [7:0] div, input logic cpol, input logic cpha);
    @(posedge clk); #1;
    cfg_div = div; cfg_cpol = cpol; cfg_cpha = cpha; cfg_stb = 1'b1;
    @(posedge clk); #1;
    cfg_stb = 1'b0;
    cur_cpol = cpol;
  endtask

  // Stimulus driver: one request. lat counts clock edges after the accept edge until RES_STB is seen high.
  task automatic do_xfer(input logic [7:0] d, input logic [1:0] sel, input logic hold,
                         output logic [7:0] rx, output int lat, output logic [31:0] bits,
                         output int half, output logic [1:0] cs_and, output bit ok);
    int n;
    int ntog;
    int t1;
    logic prev;
    ok = 1'b1; lat = 0; bits = '0; half = 0; rx = '0; cs_and = 2'b11; ntog = 0; t1 = 0;
    @(posedge clk); #1;
    tx_data = d; cs_sel = sel; cs_hold = hold; tx_stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ack && n < 200);
    if (!tx_ack) begin
      ok = 1'b0;
      @(posedge clk); #1;
      tx_stb = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tx_stb = 1'b0;
    prev = sclk;
    cs_and = cs;
    while (!res_stb && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
      cs_and &= cs;
      if (sclk !== prev) begin
        ntog++;
        if (ntog == 1) t1 = lat;
        else if (ntog == 2) half = lat - t1;
        if (sclk !== cur_cpol) bits = {bits[30:0], mosi};
      end
      prev = sclk;
    end
    if (!res_stb) ok = 1'b0;
    rx = res_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_stb = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_ack !== 1'b0) begin errors++; $display("FAIL rst_tx_ack: got %b expected 0", tx_ack); end
    checks++; if (res_stb !== 1'b0) begin errors++; $display("FAIL rst_res_stb: got %b expected 0", res_stb); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL rst_res_data: got %h expected 00", res_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi: got %b expected 1", mosi); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
    checks++; if (cs !== 2'b11) begin errors++; $display("FAIL rst_cs: got %b expected 11", cs); end
    checks++; if (crc7 !== 7'h00) begin errors++; $display("FAIL rst_crc7: got %h expected 00", crc7); end
    tx_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_cpol = 1'b0;
  endtask

  task automatic test_mode0_div0();
    logic [7:0] rx; int lat; logic [31:0] bits; int half; logic [1:0] csa; bit ok;
    cfg(8'd0, 1'b0, 1'b0);
    loop_en = 1'b0; miso_drv = 1'b0;
    do_xfer(8'h40, 2'b01, 1'b0, rx, lat, bits, half, csa, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m0_complete: got ok=%0d expected 1", ok); end
    checks++; if (bits[7:0] !== 8'h40) begin errors++; $display("FAIL m0_mosi_bits: got %b expected 01000000", bits[7:0]); end
    checks++; if (lat !== 18) begin errors++; $display("FAIL m0_latency: got %0d expected 18", lat); end
    checks++; if (half !== 1) begin errors++; $display("FAIL m0_half_period: got %0d expected 1", half); end
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL m0_rx: got %h expected 00", rx); end
    checks++; if (csa !== 2'b10) begin errors++; $display("FAIL m0_cs_during: got %b expected 10", csa); end
    @(posedge clk); #1;
    checks++; if (res_stb !== 1'b0) begin errors++; $display("FAIL m0_res_stb_width: got %b expected 0", res_stb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_after: got %b expected 0", busy); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL m0_mosi_idle: got %b expected 1", mosi); end
    checks++; if (cs !== 2'b11) begin errors++; $display("FAIL m0_cs_release: got %b expected 11", cs); end
  endtask

  task automatic test_modes();
    logic [7:0] rx; int lat; logic [31:0] bits; int half; logic [1:0] csa; bit ok;
    loop_en = 1'b1;
    for (int m = 0; m < 4; m++) begin
      cfg(8'd1, m[1], m[0]);
      checks++; if (sclk !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_idle: got %b expected %b", m, sclk, m[1]); end
      do_xfer(8'hA5, 2'b01, 1'b0, rx, lat, bits, half, csa, ok);
      checks++; if (!ok || rx !== 8'hA5) begin errors++; $display("FAIL mode%0d_loopback: got %h ok=%0d expected a5", m, rx, ok); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL mode%0d_latency: got %0d expected 35", m, lat); end
      checks++; if (sclk !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_end: got %b expected %b", m, sclk, m[1]); end
    end
  endtask

  task automatic test_cfg_priority();
    int lat;
    cfg(8'd0, 1'b0, 1'b0);
    loop_en = 1'b1;
    @(posedge clk); #1;
    cfg_div = 8'd0; cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_stb = 1'b1;
    tx_data = 8'h3C; cs_sel = 2'b01; cs_hold = 1'b0; tx_stb = 1'b1;
    @(negedge clk);
    checks++; if (tx_ack !== 1'b0) begin errors++; $display("FAIL prio_no_ack: got %b expected 0", tx_ack); end
    @(posedge clk); #1;
    cfg_stb = 1'b0; cur_cpol = 1'b1;
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL prio_sclk_cpol: got %b expected 1", sclk); end
    @(negedge clk);
    checks++; if (tx_ack !== 1'b1) begin errors++; $display("FAIL prio_ack_next: got %b expected 1", tx_ack); end
    @(posedge clk); #1;
    tx_stb = 1'b0;
    lat = 0;
    while (!res_stb && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin cfg_div = 8'd5; cfg_cpol = 1'b0; cfg_stb = 1'b1; end
      if (lat == 4) cfg_stb = 1'b0;
    end
    checks++; if (lat !== 18) begin errors++; $display("FAIL busy_cfg_ignored_latency: got %0d expected 18", lat); end
    checks++; if (res_data !== 8'h3C) begin errors++; $display("FAIL prio_rx: got %h expected 3c", res_data); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL busy_cfg_ignored_cpol: got %b expected 1", sclk); end
    cfg(8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int acks; int nres; int cs_bad; int bad_ack; int rx_bad; int cyc;
    words[0] = 8'h81; words[1] = 8'h5A; words[2] = 8'hE7;
    acks = 0; nres = 0; cs_bad = 0; bad_ack = 0; rx_bad = 0; cyc = 0;
    loop_en = 1'b1;
    @(posedge clk); #1;
    tx_data = words[0]; cs_sel = 2'b01; cs_hold = 1'b1; tx_stb = 1'b1;
    while (nres < 3 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (acks >= 1 && cs !== 2'b10) cs_bad++;
      if (tx_ack && busy) bad_ack++;
      if (tx_ack) acks++;
      if (res_stb) begin
        if (res_data !== words[nres]) rx_bad++;
        nres++;
      end
      @(posedge clk); #1;
      if (acks < 3) tx_data = words[acks];
      else tx_stb = 1'b0;
    end
    checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 3", acks); end
    checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_res_count: got %0d expected 3", nres); end
    checks++; if (bad_ack !== 0) begin errors++; $display("FAIL b2b_ack_while_busy: got %0d expected 0", bad_ack); end
    checks++; if (cs_bad !== 0) begin errors++; $display("FAIL b2b_cs_low: got %0d bad cycles expected 0", cs_bad); end
    checks++; if (rx_bad !== 0) begin errors++; $display("FAIL b2b_rx: got %0d bad words expected 0", rx_bad); end
    checks++; if (cs !== 2'b10) begin errors++; $display("FAIL b2b_cs_held: got %b expected 10", cs); end
  endtask

  task automatic test_cs_mask();
    logic [7:0] rx; int lat; logic [31:0] bits; int half; logic [1:0] csa; bit ok;
    loop_en = 1'b1;
    do_xfer(8'h5A, 2'b10, 1'b0, rx, lat, bits, half, csa, ok);
    checks++; if (!ok || rx !== 8'h5A) begin errors++; $display("FAIL cs_switch_rx: got %h ok=%0d expected 5a", rx, ok); end
    checks++; if (csa !== 2'b01) begin errors++; $display("FAIL cs_switch_mask: got %b expected 01", csa); end
    checks++; if (cs !== 2'b11) begin errors++; $display("FAIL cs_switch_release: got %b expected 11", cs); end
    do_xfer(8'hC3, 2'b00, 1'b0, rx, lat, bits, half, csa, ok);
    checks++; if (!ok || rx !== 8'hC3) begin errors++; $display("FAIL cs_zero_rx: got %h ok=%0d expected c3", rx, ok); end
    checks++; if (csa !== 2'b11) begin errors++; $display("FAIL cs_zero_none: got %b expected 11", csa); end
  endtask

  task automatic test_crc();
    logic [7:0] rx; int lat; logic [31:0] bits; int half; logic [1:0] csa; bit ok;
    logic [7:0] msg [5];
    msg[0] = 8'h40; msg[1] = 8'h00; msg[2] = 8'h00; msg[3] = 8'h00; msg[4] = 8'h00;
    cfg(8'd0, 1'b0, 1'b0);
    loop_en = 1'b1;
    @(posedge clk); #1;
    crc_clr = 1'b1;
    @(posedge clk); #1;
    crc_clr = 1'b0;
    checks++; if (crc7 !== 7'h00) begin errors++; $display("FAIL crc_clear: got %h expected 00", crc7); end
    for (int i = 0; i < 5; i++) begin
      do_xfer(msg[i], 2'b01, 1'b1, rx, lat, bits, half, csa, ok);
    end
`ifdef SPI_MASTER_CRC7_EN
    checks++; if (crc7 !== 7'h4A) begin errors++; $display("FAIL crc_cmd0: got %h expected 4a", crc7); end
`else
    checks++; if (crc7 !== 7'h00) begin errors++; $display("FAIL crc_disabled: got %h expected 00", crc7); end
`endif
  endtask

  task automatic test_reset_mid();
    int n; int seen;
    cfg(8'd3, 1'b0, 1'b0);
    loop_en = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h96; cs_sel = 2'b01; cs_hold = 1'b0; tx_stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ack && n < 200);
    @(posedge clk); #1;
    tx_stb = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (cs !== 2'b11) begin errors++; $display("FAIL mid_cs: got %b expected 11", cs); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL mid_mosi: got %b expected 1", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_cpol = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (res_stb) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_res_stb: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_div62();
    logic [7:0] rx; int lat; logic [31:0] bits; int half; logic [1:0] csa; bit ok;
    loop_en = 1'b1;
    do_xfer(8'hA5, 2'b01, 1'b0, rx, lat, bits, half, csa, ok);
    checks++; if (!ok || rx !== 8'hA5) begin errors++; $display("FAIL div62_rx: got %h ok=%0d expected a5", rx, ok); end
    checks++; if (half !== 63) begin errors++; $display("FAIL div62_half_period: got %0d expected 63", half); end
    checks++; if (lat !== 1072) begin errors++; $display("FAIL div62_latency: got %0d expected 1072", lat); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; tx_stb = 1'b0; tx_data = '0; cs_sel = '0; cs_hold = 1'b0;
    cfg_stb = 1'b0; cfg_div = '0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; crc_clr = 1'b0;
    loop_en = 1'b0; miso_drv = 1'b0; cur_cpol = 1'b0;
    test_reset();
    test_mode0_div0();
    test_modes();
    test_cfg_priority();
    test_back_to_back();
    test_cs_mask();
    test_crc();
    test_reset_mid();
    test_div62();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
